timekeeper_ctrl: RTL and testbench

TIMEKEEPER_CTRL -- requirements
Module: timekeeper_ctrl

---
 rtl/timekeeper_ctrl_pkg.sv | 36 +++
 rtl/timekeeper_ctrl_tick_gen.sv | 35 +++
 rtl/timekeeper_ctrl.sv | 98 +++++++++
 tb/tb_timekeeper_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_ctrl_pkg.sv
// Shared definitions for the timekeeper controller: edit-state encoding,
// field limits, edit_field codes and a wrapping increment helper.
package timekeeper_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } state_t;

   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [5:0] HOUR_MAX = 6'd23;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] maxv);
      return (v == maxv) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [1:0] field_of(input state_t s);
      logic [1:0] f;
      case (s)
         SET_HOUR: f = FIELD_HOUR;
         SET_MIN:  f = FIELD_MIN;
         SET_SEC:  f = FIELD_SEC;
         default:  f = FIELD_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/timekeeper_ctrl_tick_gen.sv
// tick_gen: free-running prescaler for the 1 s tick and the blink phase.
//   clock    - system clock
//   reset    - async active-high reset, count -> 0
//   clear    - synchronous restart of the count at 0
//   tick     - high for one cycle when count == CLK_DIV-1
//   phase_lo - high while count < CLK_DIV/2
module tick_gen #(
   parameter int CLK_DIV = 50000000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick,
   output logic phase_lo
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

   logic [CW-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear || count == LAST)
         count <= '0;
      else
         count <= count + CW'(1);
   end

   assign tick     = (count == LAST);
   assign phase_lo = (count < HALF);

endmodule

// File: rtl/timekeeper_ctrl.sv
// timekeeper_ctrl: 24 h clock with a mode/inc button editor.
//   clock, reset        - system clock, async active-high reset
//   mode_btn, inc_btn   - debounced one-cycle button pulses
//   sec, min, hour      - registered time of day
//   edit_field          - 0 none, 1 hour, 2 min, 3 sec
//   blink               - blink enable for the field being edited
//   chime               - one-cycle pulse after each hour rollover in RUN
//
// state    | meaning
// RUN      | time advances on each tick, inc_btn ignored
// SET_HOUR | time frozen, inc_btn bumps hour mod 24
// SET_MIN  | time frozen, inc_btn bumps min mod 60
// SET_SEC  | time frozen, inc_btn bumps sec mod 60; leaving restarts prescaler
module timekeeper_ctrl
   import timekeeper_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [5:0] hour,
   output logic [1:0] edit_field,
   output logic       blink,
   output logic       chime
);

   state_t state, state_d;
   logic   tick, phase_lo, clear, inc_ok, run_tick;

   tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .tick     (tick),
      .phase_lo (phase_lo)
   );

   always_comb begin
      state_d = state;
      if (mode_btn) begin
         case (state)
            RUN:      state_d = SET_HOUR;
            SET_HOUR: state_d = SET_MIN;
            SET_MIN:  state_d = SET_SEC;
            default:  state_d = RUN;
         endcase
      end
   end

   // Restart the second on exit from editing so the first one is full length.
   assign clear    = mode_btn && (state == SET_SEC);
   // A simultaneous mode press wins; the increment is dropped.
   assign inc_ok   = inc_btn && !mode_btn;
   assign run_tick = tick && (state == RUN);
   assign blink    = (state != RUN) && phase_lo;

   // edit_field is registered from the next state so it lines up with state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         edit_field <= FIELD_NONE;
      end else begin
         state      <= state_d;
         edit_field <= field_of(state_d);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sec   <= '0;
         min   <= '0;
         hour  <= '0;
         chime <= 1'b0;
      end else begin
         chime <= run_tick && (sec == SEC_MAX) && (min == MIN_MAX);
         case (state)
            RUN: begin
               if (tick) begin
                  sec <= wrap_inc(sec, SEC_MAX);
                  if (sec == SEC_MAX) begin
                     min <= wrap_inc(min, MIN_MAX);
                     if (min == MIN_MAX)
                        hour <= wrap_inc(hour, HOUR_MAX);
                  end
               end
            end
            SET_HOUR: if (inc_ok) hour <= wrap_inc(hour, HOUR_MAX);
            SET_MIN:  if (inc_ok) min  <= wrap_inc(min, MIN_MAX);
            default:  if (inc_ok) sec  <= wrap_inc(sec, SEC_MAX);
         endcase
      end
   end

endmodule

// File: tb/tb_timekeeper_ctrl.sv
module tb_timekeeper_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       mode_btn = 1'b0;
   logic       inc_btn = 1'b0;
   logic [5:0] sec, min, hour;
   logic [1:0] edit_field;
   logic       blink, chime;

   int checks = 0;
   int failures = 0;
   int chime_cnt = 0;

   timekeeper_ctrl #(.CLK_DIV(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .mode_btn   (mode_btn),
      .inc_btn    (inc_btn),
      .sec        (sec),
      .min        (min),
      .hour       (hour),
      .edit_field (edit_field),
      .blink      (blink),
      .chime      (chime)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (chime) chime_cnt++;

   typedef struct {
      logic mode;
      logic inc;
      int   edit;
      int   h;
      int   m;
      int   s;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step(input logic m, input logic i);
      mode_btn = m;
      inc_btn  = i;
      @(posedge clock);
      #1;
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
   endtask

   task automatic do_reset();
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      reset    = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic chk_time(input string name, input int h, input int m, input int s);
      chk({name, "_hour"}, hour, h);
      chk({name, "_min"},  min,  m);
      chk({name, "_sec"},  sec,  s);
   endtask

   initial begin
      int first;
      int held_sec;
      logic b[20];
      int ones, bad;

      vecs[0]  = '{1'b1, 1'b0, 1, 0, 0, 0};
      vecs[1]  = '{1'b0, 1'b1, 1, 1, 0, 0};
      vecs[2]  = '{1'b0, 1'b1, 1, 2, 0, 0};
      vecs[3]  = '{1'b1, 1'b1, 2, 2, 0, 0};
      vecs[4]  = '{1'b0, 1'b1, 2, 2, 1, 0};
      vecs[5]  = '{1'b1, 1'b0, 3, 2, 1, 0};
      vecs[6]  = '{1'b0, 1'b1, 3, 2, 1, 1};
      vecs[7]  = '{1'b0, 1'b1, 3, 2, 1, 2};
      vecs[8]  = '{1'b0, 1'b0, 3, 2, 1, 2};
      vecs[9]  = '{1'b1, 1'b0, 0, 2, 1, 2};
      vecs[10] = '{1'b0, 1'b1, 0, 2, 1, 2};
      vecs[11] = '{1'b0, 1'b0, 0, 2, 1, 2};

      // reset state and free run for 240 cycles
      do_reset();
      chk("rst_edit", edit_field, 0);
      chk("rst_blink", blink, 0);
      chk("rst_chime", chime, 0);
      chk_time("rst", 0, 0, 0);
      chime_cnt = 0;
      repeat (3) step(0, 0);
      chk("pre_first_tick_sec", sec, 0);
      step(0, 0);
      chk("first_tick_sec", sec, 1);
      repeat (236) step(0, 0);
      chk_time("run240", 0, 1, 0);
      chk("run240_chime_cnt", chime_cnt, 0);
      step(1, 0);
      chk("enter_set_hour_edit", edit_field, 1);
      chk_time("enter_set_hour", 0, 1, 0);

      // table-driven edit sequence
      do_reset();
      foreach (vecs[k]) begin
         step(vecs[k].mode, vecs[k].inc);
         chk($sformatf("vec%0d_edit", k), edit_field, vecs[k].edit);
         chk_time($sformatf("vec%0d", k), vecs[k].h, vecs[k].m, vecs[k].s);
         chk($sformatf("vec%0d_chime", k), chime, 0);
         if (vecs[k].edit == 0) chk($sformatf("vec%0d_blink", k), blink, 0);
      end

      // preload 23:59:58, return to RUN, two ticks to midnight
      do_reset();
      step(1, 0);
      repeat (23) step(0, 1);
      step(1, 0);
      repeat (59) step(0, 1);
      step(1, 0);
      repeat (58) step(0, 1);
      chime_cnt = 0;
      step(1, 0);
      chk("preload_edit", edit_field, 0);
      chk_time("preload", 23, 59, 58);
      repeat (3) step(0, 0);
      chk("full_second_after_edit", sec, 58);
      step(0, 0);
      chk_time("tick1", 23, 59, 59);
      chk("tick1_chime", chime, 0);
      repeat (4) step(0, 0);
      chk_time("midnight", 0, 0, 0);
      chk("midnight_chime", chime, 1);
      step(0, 0);
      chk("midnight_chime_drop", chime, 0);
      step(0, 0);
      chk("midnight_chime_cnt", chime_cnt, 1);

      // min 59 -> 0 in SET_MIN without carry or chime
      do_reset();
      step(1, 0);
      repeat (5) step(0, 1);
      step(1, 0);
      repeat (59) step(0, 1);
      chk_time("setmin59", 5, 59, 0);
      chime_cnt = 0;
      step(0, 1);
      chk_time("setmin_wrap", 5, 0, 0);
      chk("setmin_wrap_chime", chime, 0);
      step(0, 0);
      chk("setmin_wrap_chime_cnt", chime_cnt, 0);

      // hold in SET_SEC: time frozen, blink period 4 with 2 high
      step(1, 0);
      chk("setsec_edit", edit_field, 3);
      held_sec = sec;
      for (int k = 0; k < 20; k++) begin
         step(0, 0);
         b[k] = blink;
      end
      chk("setsec_hold_sec", sec, held_sec);
      chk_time("setsec_hold", 5, 0, 0);
      ones = 0;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (b[k]) ones++;
         if (k >= 2 && b[k] == b[k-2]) bad++;
      end
      chk("blink_high_count", ones, 10);
      chk("blink_period_errors", bad, 0);

      // reset mid-edit in SET_SEC
      do_reset();
      step(1, 0);
      step(0, 1);
      step(0, 1);
      step(1, 0);
      step(0, 1);
      step(1, 0);
      step(0, 1);
      chk_time("pre_reset", 2, 1, 1);
      step(0, 0);
      step(0, 0);
      #3;
      reset = 1'b1;
      #1;
      chk_time("async_reset", 0, 0, 0);
      chk("async_reset_edit", edit_field, 0);
      chk("async_reset_blink", blink, 0);
      chk("async_reset_chime", chime, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clock); #1;
         if (first == 0 && sec != 0) first = k;
      end
      chk("first_tick_after_reset", first, 4);
      chk("post_reset_edit", edit_field, 0);
      chk("post_reset_min", min, 0);
      chk("post_reset_hour", hour, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
